// File: rtl/switch_reader.sv
// -----------------------------------------------------------------------------
// switch_reader
//
// Purpose:
//   Reads raw board switch pins and turns them into clean levels for the
//   application logic. Each pin may pass through a two-flop synchroniser.
//   Each bit is then debounced by its own counter. Every accepted level change
//   is reported as an event on a valid/ready handshake. If the consumer has
//   not yet taken the pending event, later changes are merged into it.
//
// Build option:
//   SWITCH_READER_SYNC_EN - when defined, a two-flop synchroniser sits in
//                           front of the debounce counters. Latency from pin
//                           to state is then DEBOUNCE+2 edges.
//                           When undefined, the counters sample `switches`
//                           directly. Latency is then DEBOUNCE edges. Use this
//                           mode only for inputs that are already synchronous
//                           to clk.
//
// Parameters:
//   WIDTH       - number of switch inputs
//   DEBOUNCE    - consecutive cycles a new level must persist (2..65535)
//   RESET_STATE - reset value of the synchroniser, stable and event-value
//                 registers
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   switches     in   raw switch pins [WIDTH]
//   state        out  debounced stable levels [WIDTH]
//   evt_valid    out  change event pending
//   evt_ready    in   consumer accepts the event (ignored when evt_valid=0)
//   evt_value    out  state captured at the most recent merged change [WIDTH]
//   evt_changed  out  bits changed since the last accepted event [WIDTH]
//   evt_overflow out  more than one change merged into the pending event
// -----------------------------------------------------------------------------
module switch_reader #(
  parameter int               WIDTH       = 8,
  parameter int               DEBOUNCE    = 16,
  parameter logic [WIDTH-1:0] RESET_STATE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_value,
  output logic [WIDTH-1:0] evt_changed,
  output logic             evt_overflow
);

  // The counter only has to hold values up to DEBOUNCE-1.
  localparam int            CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  // Level presented to the debounce counters.
  logic [WIDTH-1:0] deb_in;

  // ---------------------------------------------------------------------------
  // Optional input synchroniser
  // ---------------------------------------------------------------------------
`ifdef SWITCH_READER_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = switches;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RESET_STATE;
      sync2_q <= RESET_STATE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign deb_in = sync2_q;
`else
  // The inputs are already synchronous to clk, so they feed the counters
  // directly.
  assign deb_in = switches;
`endif

  // ---------------------------------------------------------------------------
  // Per-bit debounce
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] chg;  // bits whose stable level flips on this edge

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_bit_d;
    logic          chg_bit;

    always_comb begin
      cnt_d        = cnt_q;
      stable_bit_d = stable_q[gi];
      chg_bit      = 1'b0;
      if (deb_in[gi] == stable_q[gi]) begin
        // The input agrees with the stable level. Any partial count is
        // discarded, so a short glitch leaves no trace.
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        // This is the DEBOUNCE-th consecutive disagreeing sample.
        // The new level is accepted.
        stable_bit_d = deb_in[gi];
        cnt_d        = '0;
        chg_bit      = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stable_d[gi] = stable_bit_d;
    assign chg[gi]      = chg_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= RESET_STATE;
    end else begin
      stable_q <= stable_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event register
  // ---------------------------------------------------------------------------
  logic             evt_valid_q,    evt_valid_d;
  logic [WIDTH-1:0] evt_value_q,    evt_value_d;
  logic [WIDTH-1:0] evt_changed_q,  evt_changed_d;
  logic             evt_overflow_q, evt_overflow_d;
  logic             xfer;

  always_comb begin
    evt_valid_d    = evt_valid_q;
    evt_value_d    = evt_value_q;
    evt_changed_d  = evt_changed_q;
    evt_overflow_d = evt_overflow_q;
    xfer           = evt_valid_q & evt_ready;

    if (|chg) begin
      // evt_value takes the post-edge stable level. This keeps it identical
      // to `state` on the edge where the change lands.
      evt_value_d = stable_d;
      if (!evt_valid_q || xfer) begin
        // Either the slot is empty, or it is being emptied on this edge.
        // Start a fresh event in both cases.
        evt_valid_d    = 1'b1;
        evt_changed_d  = chg;
        evt_overflow_d = 1'b0;
      end else begin
        // The consumer still holds the old event, so merge this change into
        // it. A bit that flips back keeps its changed flag; the mask records
        // activity, not a net difference.
        evt_changed_d  = evt_changed_q | chg;
        evt_overflow_d = 1'b1;
      end
    end else if (xfer) begin
      // evt_value is left holding the last reported level.
      evt_valid_d    = 1'b0;
      evt_changed_d  = '0;
      evt_overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q    <= 1'b0;
      evt_value_q    <= RESET_STATE;
      evt_changed_q  <= '0;
      evt_overflow_q <= 1'b0;
    end else begin
      evt_valid_q    <= evt_valid_d;
      evt_value_q    <= evt_value_d;
      evt_changed_q  <= evt_changed_d;
      evt_overflow_q <= evt_overflow_d;
    end
  end

  // Every output comes straight from a flop. There is no combinational path
  // from evt_ready to any output.
  assign state        = stable_q;
  assign evt_valid    = evt_valid_q;
  assign evt_value    = evt_value_q;
  assign evt_changed  = evt_changed_q;
  assign evt_overflow = evt_overflow_q;

endmodule
